// File: rtl/trivium_pkg.sv
// Shared constants, FSM state type and parameter check for the Trivium keystream core.
package trivium_pkg;

  localparam int KEY_BYTES    = 10;
  localparam int IV_BYTES     = 10;
  localparam int LOAD_BYTES   = KEY_BYTES + IV_BYTES;
  localparam int STATE_BITS   = 288;
  localparam int WARMUP_STEPS = 1152;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  // Steps per cycle must divide the warm-up evenly and stay a power of two up to 64.
  function automatic bit w_is_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
           (w == 16) || (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/trivium_keystream_gen_if.sv
// Load and keystream handshake bundle of the Trivium keystream core.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1; the source holds its data stable while
// valid=1 and ready=0; ready never depends combinationally on valid.
// init is a one-cycle command that wins over any transfer in the same cycle.
interface trivium_keystream_gen_if #(parameter int W = 8);
  logic         init;
  logic         load_valid;
  logic [7:0]   load_data;
  logic         load_ready;
  logic         ks_valid;
  logic         ks_ready;
  logic [W-1:0] ks_data;
  logic         busy;

  modport master (
    output init, load_valid, load_data, ks_ready,
    input  load_ready, ks_valid, ks_data, busy
  );

  modport slave (
    input  init, load_valid, load_data, ks_ready,
    output load_ready, ks_valid, ks_data, busy
  );
endinterface

// File: rtl/trivium_round.sv
// One combinational Trivium step: 288-bit state in, advanced state and one keystream bit out.
// Bit index k of the vectors holds Trivium state bit s(k+1).
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_BITS-1:0] s_in,
  output logic [STATE_BITS-1:0] s_out,
  output logic                  z
);

  logic t1, t2, t3;
  logic f1, f2, f3;

  // Output taps, nonlinear feedback and the three register shifts.
  always_comb begin
    t1    = s_in[65]  ^ s_in[92];
    t2    = s_in[161] ^ s_in[176];
    t3    = s_in[242] ^ s_in[287];
    z     = t1 ^ t2 ^ t3;
    f1    = t1 ^ (s_in[90]  & s_in[91])  ^ s_in[170];
    f2    = t2 ^ (s_in[174] & s_in[175]) ^ s_in[263];
    f3    = t3 ^ (s_in[285] & s_in[286]) ^ s_in[68];
    s_out = {s_in[286:177], f2, s_in[175:93], f1, s_in[91:0], f3};
  end

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: byte-wise key/IV load, 1152-step warm-up,
// then W keystream bits per accepted word (bit 0 is the earliest bit).
module trivium_keystream_gen
  import trivium_pkg::*;
#(
  parameter int W = 8
)
(
  input  logic                   clk,
  input  logic                   rst,
  trivium_keystream_gen_if.slave bus,
  output state_t                 state_dbg
);

  localparam int WARM_CYCLES = WARMUP_STEPS / W;
  localparam int WCW         = $clog2(WARM_CYCLES + 1);

  if (!w_is_legal(W)) begin : g_bad_w
    $error("trivium_keystream_gen: W must be 1, 2, 4, 8, 16, 32 or 64");
  end

  state_t                st, st_nxt;
  logic [4:0]            byte_cnt;
  logic [WCW-1:0]        warm_cnt;
  logic [STATE_BITS-1:0] s;
  logic [STATE_BITS-1:0] s_adv;
  logic [W-1:0]          z_vec;
  logic [8:0]            base;
  logic                  accept;
  logic                  xfer;
  logic                  last_byte;
  logic                  warm_done;

  // init wins over a byte accept or a keystream transfer in the same cycle.
  assign accept    = bus.load_valid && (st == LOAD) && !bus.init;
  assign xfer      = (st == RUN) && bus.ks_ready && !bus.init;
  assign last_byte = accept && (byte_cnt == 5'(LOAD_BYTES - 1));
  assign warm_done = (warm_cnt == WCW'(WARM_CYCLES - 1));

  // Chain of W single-step rounds; z bit g is keystream bit g of the word.
  for (genvar g = 0; g < W; g++) begin : g_round
    logic [STATE_BITS-1:0] cur;
    logic [STATE_BITS-1:0] nxt;
    logic                  zb;
    if (g == 0) begin : g_first
      assign cur = s;
    end else begin : g_next
      assign cur = g_round[g-1].nxt;
    end
    trivium_round u_round (
      .s_in  (cur),
      .s_out (nxt),
      .z     (zb)
    );
    assign z_vec[g] = zb;
  end
  assign s_adv = g_round[W-1].nxt;

  // Key bytes land at s1.., IV bytes at s94..; bit j of byte i is the (8i+j+1)th bit.
  always_comb begin
    base = 9'd0;
    if (byte_cnt < 5'(KEY_BYTES)) base = 9'(byte_cnt) * 9'd8;
    else                          base = 9'd93 + 9'(byte_cnt - 5'(KEY_BYTES)) * 9'd8;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    st_nxt = st;
    if (bus.init) begin
      st_nxt = LOAD;
    end else begin
      case (st)
        IDLE:    st_nxt = IDLE;
        LOAD:    if (last_byte) st_nxt = WARMUP;
        WARMUP:  if (warm_done) st_nxt = RUN;
        RUN:     st_nxt = RUN;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Byte and warm-up counters, both restarted by init.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      warm_cnt <= '0;
    end else if (bus.init) begin
      byte_cnt <= '0;
      warm_cnt <= '0;
    end else begin
      if (accept)        byte_cnt <= byte_cnt + 5'd1;
      if (st == WARMUP)  warm_cnt <= warm_cnt + WCW'(1);
    end
  end

  // Cipher state: cleared on init, filled byte-wise, advanced in warm-up and per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else if (bus.init) begin
      s <= '0;
    end else if (accept) begin
      s[base +: 8] <= bus.load_data;
      if (last_byte) s[287:285] <= 3'b111;
    end else if ((st == WARMUP) || xfer) begin
      s <= s_adv;
    end
  end

  assign bus.load_ready = (st == LOAD);
  assign bus.ks_valid   = (st == RUN);
  assign bus.ks_data    = (st == RUN) ? z_vec : '0;
  assign bus.busy       = (st == LOAD) || (st == WARMUP);
  assign state_dbg      = st;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen with W=1, 8 and 64 instances sharing
// the load inputs; expected keystream comes from a bit-serial Trivium model.
module tb_trivium_keystream_gen;
  import trivium_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       load_valid;
  logic [7:0] load_data;
  logic       rdy1, rdy8, rdy64;
  state_t     st1, st8, st64;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ld_b [20];
  logic       exp_bits [$];

  trivium_keystream_gen_if #(.W(1))  if1 ();
  trivium_keystream_gen_if #(.W(8))  if8 ();
  trivium_keystream_gen_if #(.W(64)) if64 ();

  assign if1.init        = init;
  assign if1.load_valid  = load_valid;
  assign if1.load_data   = load_data;
  assign if1.ks_ready    = rdy1;
  assign if8.init        = init;
  assign if8.load_valid  = load_valid;
  assign if8.load_data   = load_data;
  assign if8.ks_ready    = rdy8;
  assign if64.init       = init;
  assign if64.load_valid = load_valid;
  assign if64.load_data  = load_data;
  assign if64.ks_ready   = rdy64;

  trivium_keystream_gen #(.W(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave),  .state_dbg(st1));
  trivium_keystream_gen #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .state_dbg(st8));
  trivium_keystream_gen #(.W(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave), .state_dbg(st64));

  // Clock.
  always #5 clk = ~clk;

  // Bit-serial reference model, 1-based state indexing; fills exp_bits with nbits.
  task automatic model_gen(input int nbits);
    logic [1:288] ms;
    logic t1, t2, t3, z;
    ms = '0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) begin
        ms[8*i + j + 1]  = ld_b[i][j];
        ms[94 + 8*i + j] = ld_b[10 + i][j];
      end
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    exp_bits.delete();
    for (int n = 0; n < 1152 + nbits; n++) begin
      t1 = ms[66] ^ ms[93];
      t2 = ms[162] ^ ms[177];
      t3 = ms[243] ^ ms[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
      t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
      t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
      if (n >= 1152) exp_bits.push_back(z);
      ms = {t3, ms[1:92], t1, ms[94:176], t2, ms[178:287]};
    end
  endtask

  // Driver: one-cycle init pulse; returns on the following falling edge.
  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Driver: 20 back-to-back bytes from ld_b; returns on the falling edge after the last accept.
  task automatic send_key();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = ld_b[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Driver: wait (bounded) for the W=8 instance to present keystream.
  task automatic wait_run8();
    for (int c = 0; c < 2000; c++) begin
      if (if8.ks_valid === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (st8 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st8, IDLE); end
    n_tests++;
    if (if8.load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_load_ready: got %b want 0", if8.load_ready); end
    n_tests++;
    if (if8.ks_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ks_valid: got %b want 0", if8.ks_valid); end
    n_tests++;
    if (if8.ks_data !== 8'h00) begin n_fail++; $display("FAIL reset_ks_data: got %h want 00", if8.ks_data); end
    n_tests++;
    if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
    n_tests++;
    if (if64.ks_data !== 64'h0) begin n_fail++; $display("FAIL reset_ks_data64: got %h want 0", if64.ks_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (st8 !== IDLE) begin n_fail++; $display("FAIL reset_release_idle: got %0d want %0d", st8, IDLE); end
  endtask

  task automatic test_zero_key();
    int lat1, lat8, lat64;
    logic [7:0] e8;
    lat1 = -1; lat8 = -1; lat64 = -1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) ld_b[i] = 8'h00;
    model_gen(64);
    do_init();
    n_tests++;
    if (st8 !== LOAD || if8.load_ready !== 1'b1 || if8.busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_enter_load: state %0d ready %b busy %b want LOAD/1/1", st8, if8.load_ready, if8.busy);
    end
    send_key();
    for (int c = 1; c < 2000; c++) begin
      if (lat1  < 0 && if1.ks_valid  === 1'b1) lat1  = c;
      if (lat8  < 0 && if8.ks_valid  === 1'b1) lat8  = c;
      if (lat64 < 0 && if64.ks_valid === 1'b1) lat64 = c;
      if (lat1 >= 0 && lat8 >= 0 && lat64 >= 0) break;
      @(negedge clk);
    end
    n_tests++;
    if (lat8 != 145) begin n_fail++; $display("FAIL zero_latency_w8: got %0d want 145", lat8); end
    n_tests++;
    if (lat1 != 1153) begin n_fail++; $display("FAIL zero_latency_w1: got %0d want 1153", lat1); end
    n_tests++;
    if (lat64 != 19) begin n_fail++; $display("FAIL zero_latency_w64: got %0d want 19", lat64); end
    n_tests++;
    if (if8.busy !== 1'b0 || st8 !== RUN) begin n_fail++; $display("FAIL zero_run_state: state %0d busy %b want RUN/0", st8, if8.busy); end
    rdy8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*k + b];
      n_tests++;
      if (if8.ks_valid !== 1'b1 || if8.ks_data !== e8) begin
        n_fail++; $display("FAIL zero_word%0d: valid %b data %h want 1/%h", k, if8.ks_valid, if8.ks_data, e8);
      end
      @(negedge clk);
    end
    rdy8 = 1'b0;
  endtask

  task automatic test_single_bit_key();
    int p1, p8, p64;
    logic [7:0]  e8;
    logic [63:0] e64;
    p1 = 0; p8 = 0; p64 = 0;
    for (int i = 0; i < 20; i++) ld_b[i] = 8'h00;
    ld_b[0] = 8'h80;
    model_gen(512);
    do_init();
    send_key();
    for (int c = 0; c < 4000; c++) begin
      if (p1 >= 512 && p8 >= 64 && p64 >= 8) break;
      if (if1.ks_valid === 1'b1 && p1 < 512) begin
        rdy1 = 1'b1;
        n_tests++;
        if (if1.ks_data !== exp_bits[p1]) begin
          n_fail++; $display("FAIL onebit_w1_bit%0d: got %b want %b", p1, if1.ks_data, exp_bits[p1]);
        end
        p1++;
      end else rdy1 = 1'b0;
      if (if8.ks_valid === 1'b1 && p8 < 64) begin
        rdy8 = 1'b1;
        for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*p8 + b];
        n_tests++;
        if (if8.ks_data !== e8) begin
          n_fail++; $display("FAIL onebit_w8_word%0d: got %h want %h", p8, if8.ks_data, e8);
        end
        p8++;
      end else rdy8 = 1'b0;
      if (if64.ks_valid === 1'b1 && p64 < 8) begin
        rdy64 = 1'b1;
        for (int b = 0; b < 64; b++) e64[b] = exp_bits[64*p64 + b];
        n_tests++;
        if (if64.ks_data !== e64) begin
          n_fail++; $display("FAIL onebit_w64_word%0d: got %h want %h", p64, if64.ks_data, e64);
        end
        p64++;
      end else rdy64 = 1'b0;
      @(negedge clk);
    end
    rdy1 = 1'b0; rdy8 = 1'b0; rdy64 = 1'b0;
    n_tests++;
    if (p1 != 512 || p8 != 64 || p64 != 8) begin
      n_fail++; $display("FAIL onebit_counts: got %0d/%0d/%0d want 512/64/8", p1, p8, p64);
    end
  endtask

  task automatic test_random_ready();
    int ptr;
    logic [7:0] e8;
    logic [0:0] r;
    ptr = 0;
    for (int i = 0; i < 20; i++) ld_b[i] = 8'(i * 37 + 5);
    model_gen(8000);
    do_init();
    send_key();
    wait_run8();
    for (int c = 0; c < 6000 && ptr < 1000; c++) begin
      r = 1'($urandom_range(0, 1));
      rdy8 = r[0];
      for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*ptr + b];
      n_tests++;
      if (if8.ks_valid !== 1'b1 || if8.ks_data !== e8) begin
        n_fail++; $display("FAIL rand_word%0d: valid %b data %h want 1/%h", ptr, if8.ks_valid, if8.ks_data, e8);
      end
      if (r[0]) ptr++;
      @(negedge clk);
    end
    rdy8 = 1'b0;
    n_tests++;
    if (ptr != 1000) begin n_fail++; $display("FAIL rand_transfers: got %0d want 1000", ptr); end
    n_tests++;
    if (st8 !== RUN) begin n_fail++; $display("FAIL rand_stays_run: got %0d want %0d", st8, RUN); end
  endtask

  task automatic test_init_restart();
    logic [7:0] e8;
    for (int sc = 0; sc < 3; sc++) begin
      for (int i = 0; i < 20; i++) ld_b[i] = 8'(i * 11 + sc * 53 + 1);
      do_init();
      if (sc == 0) begin
        for (int i = 0; i < 7; i++) begin
          @(negedge clk); load_valid = 1'b1; load_data = 8'hAA;
        end
        @(negedge clk); load_valid = 1'b1; load_data = 8'h55; init = 1'b1;
        @(negedge clk); load_valid = 1'b0; init = 1'b0;
      end else if (sc == 1) begin
        send_key();
        repeat (50) @(negedge clk);
        n_tests++;
        if (st8 !== WARMUP) begin n_fail++; $display("FAIL restart_pre_warmup: got %0d want %0d", st8, WARMUP); end
        do_init();
      end else begin
        send_key();
        wait_run8();
        rdy8 = 1'b1; init = 1'b1;
        @(negedge clk); rdy8 = 1'b0; init = 1'b0;
      end
      n_tests++;
      if (st8 !== LOAD || if8.ks_valid !== 1'b0 || if8.busy !== 1'b1) begin
        n_fail++; $display("FAIL restart%0d_load: state %0d valid %b busy %b want LOAD/0/1", sc, st8, if8.ks_valid, if8.busy);
      end
      for (int i = 0; i < 20; i++) ld_b[i] = 8'(i * 29 + sc * 71 + 3);
      model_gen(64);
      send_key();
      wait_run8();
      rdy8 = 1'b1;
      for (int k = 0; k < 8; k++) begin
        for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*k + b];
        n_tests++;
        if (if8.ks_valid !== 1'b1 || if8.ks_data !== e8) begin
          n_fail++; $display("FAIL restart%0d_word%0d: valid %b data %h want 1/%h", sc, k, if8.ks_valid, if8.ks_data, e8);
        end
        @(negedge clk);
      end
      rdy8 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_warmup();
    logic [7:0] e8;
    for (int i = 0; i < 20; i++) ld_b[i] = 8'(255 - i * 7);
    do_init();
    send_key();
    repeat (30) @(negedge clk);
    n_tests++;
    if (st8 !== WARMUP || if64.ks_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: state8 %0d valid64 %b want WARMUP/1", st8, if64.ks_valid);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (st8 !== IDLE || if8.busy !== 1'b0 || if8.load_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async8: state %0d busy %b ready %b want IDLE/0/0", st8, if8.busy, if8.load_ready);
    end
    n_tests++;
    if (if64.ks_valid !== 1'b0 || if64.ks_data !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_async64: valid %b data %h want 0/0", if64.ks_valid, if64.ks_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (st8 !== IDLE || st1 !== IDLE) begin n_fail++; $display("FAIL rstmid_stay_idle: got %0d/%0d want %0d", st8, st1, IDLE); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); load_valid = 1'b1; load_data = 8'($urandom);
      #1;
      n_tests++;
      if (if8.load_ready !== 1'b0) begin n_fail++; $display("FAIL idle_load_ready%0d: got %b want 0", k, if8.load_ready); end
      @(negedge clk); load_valid = 1'b0;
    end
    n_tests++;
    if (st8 !== IDLE || if8.busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_bytes: state %0d busy %b want IDLE/0", st8, if8.busy); end
    for (int i = 0; i < 20; i++) ld_b[i] = 8'(i * 3 + 100);
    model_gen(64);
    do_init();
    send_key();
    wait_run8();
    rdy8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*k + b];
      n_tests++;
      if (if8.ks_valid !== 1'b1 || if8.ks_data !== e8) begin
        n_fail++; $display("FAIL rstmid_word%0d: valid %b data %h want 1/%h", k, if8.ks_valid, if8.ks_data, e8);
      end
      @(negedge clk);
    end
    rdy8 = 1'b0;
  endtask

  task automatic test_load_gaps();
    logic [7:0] e8;
    int gaps;
    for (int i = 0; i < 20; i++) ld_b[i] = 8'(i * 91 + 17);
    model_gen(64);
    do_init();
    for (int i = 0; i < 20; i++) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk); load_valid = 1'b0; load_data = 8'($urandom);
      end
      @(negedge clk);
      if (i == 10) begin
        n_tests++;
        if (st8 !== LOAD) begin n_fail++; $display("FAIL gaps_mid_load: got %0d want %0d", st8, LOAD); end
      end
      load_valid = 1'b1; load_data = ld_b[i];
    end
    @(negedge clk); load_valid = 1'b0;
    wait_run8();
    rdy8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 8; b++) e8[b] = exp_bits[8*k + b];
      n_tests++;
      if (if8.ks_valid !== 1'b1 || if8.ks_data !== e8) begin
        n_fail++; $display("FAIL gaps_word%0d: valid %b data %h want 1/%h", k, if8.ks_valid, if8.ks_data, e8);
      end
      @(negedge clk);
    end
    rdy8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    rdy1 = 1'b0; rdy8 = 1'b0; rdy64 = 1'b0;
    test_reset();
    test_zero_key();
    test_single_bit_key();
    test_random_ready();
    test_init_restart();
    test_reset_mid_warmup();
    test_load_gaps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trivium_keystream_gen.md
TRIVIUM_KEYSTREAM_GEN -- requirements
Module: trivium_keystream_gen

Interface
REQ-001 SHALL have parameter W, default 8, meaning keystream bits produced per cycle; legal values 1,2,4,8,16,32,64.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port init  input  1  single-cycle pulse that starts a new key/IV load.
REQ-005 SHALL have port load_valid  input  1  load_data holds a valid byte.
REQ-006 SHALL have port load_data  input  8  key/IV byte.
REQ-007 SHALL have port load_ready  output  1  core accepts a byte this cycle.
REQ-008 SHALL have port ks_valid  output  1  ks_data holds valid keystream.
REQ-009 SHALL have port ks_ready  input  1  consumer takes ks_data this cycle.
REQ-010 SHALL have port ks_data  output  W  keystream word; bit 0 is the earliest keystream bit.
REQ-011 SHALL have port busy  output  1  high in LOAD or WARMUP.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, WARMUP, RUN.
REQ-013 SHALL move from any state to LOAD on init=1, clearing the byte counter and the 288-bit state, with ks_valid=0 from the next cycle.
REQ-014 SHALL drive load_ready=1 only in LOAD; a byte is accepted when load_valid and load_ready are both 1.
REQ-015 SHALL accept exactly 20 bytes: bytes 0-9 are key, bytes 10-19 are IV; bit j of key byte i maps to key bit K(8i+j+1), and IV bytes map the same way to IV(8i+j+1).
REQ-016 SHALL load the state on the 20th accepted byte: s1..s80=K1..K80, s81..s93=0, s94..s173=IV1..IV80, s174..s285=0, s286..s288=1; then enter WARMUP.
REQ-017 SHALL in WARMUP advance W Trivium steps per cycle for 1152/W cycles, discarding output, then enter RUN.
REQ-018 SHALL compute each step as: t1=s66^s93, t2=s162^s177, t3=s243^s288; z=t1^t2^t3; t1^=(s91&s92)^s171; t2^=(s175&s176)^s264; t3^=(s286&s287)^s69; shift s1..s93 in t3, s94..s177 in t1, s178..s288 in t2.
REQ-019 SHALL in RUN hold ks_valid=1 and present the next W z bits on ks_data.
REQ-020 SHALL advance state by W steps only on ks_valid&&ks_ready; when ks_ready=0, ks_data and state SHALL hold unchanged.
REQ-021 SHALL remain in RUN indefinitely; no further key/IV is taken without init.
REQ-022 SHALL give init priority over a simultaneous byte accept or keystream transfer; that byte or word is discarded.
REQ-023 SHALL ignore load_valid outside LOAD.
REQ-024 SHALL make the first RUN ks_data valid on the cycle after the last WARMUP cycle; total latency from the 20th byte accept to ks_valid is 1152/W+1 cycles.

Reset
REQ-025 SHALL on rst=1 immediately force state IDLE, the 288-bit state to 0, the byte counter and warm-up counter to 0, and drive load_ready=0, ks_valid=0, ks_data=0, busy=0.
REQ-026 SHALL, when rst deasserts mid-LOAD or mid-WARMUP, stay in IDLE until init.

Structure
REQ-027 SHALL take KEY_BYTES=10, IV_BYTES=10, STATE_BITS=288, WARMUP_STEPS=1152 and the FSM state enum from shared package trivium_pkg.
REQ-028 SHALL instantiate combinational sub-module trivium_round (288-bit state in -> next state and z) W times in a generate chain.
REQ-029 SHALL reject illegal W at elaboration.

Verification
REQ-030 SHALL check: rst, init, 20 bytes 0x00 -> ks_valid rises exactly 1152/W+1 cycles after byte 20; first 64 bits match the golden bit-serial model for key=0, IV=0.
REQ-031 SHALL check: key byte0=0x80, other bytes 0x00 -> 512 bits match the golden model for W=1, 8 and 64, with identical streams.
REQ-032 SHALL check: random ks_ready (50%) for 1000 transfers -> concatenated accepted words equal the model stream, with no gaps or repeats.
REQ-033 SHALL check: init asserted at byte 7 of LOAD, then in mid-WARMUP, then in RUN together with a ks_ready transfer -> each restarts cleanly; the next stream matches the new key/IV.
REQ-034 SHALL check: rst pulsed for 1 cycle mid-WARMUP -> all outputs 0 asynchronously; load_valid pulses before init produce load_ready=0 and no state change.
REQ-035 SHALL check: load_valid toggled with gaps during LOAD -> only handshaked bytes counted; IDLE ignores bytes.
